mul_product_accumulator: RTL and testbench
==========================================

// Module: mul_product_accumulator
// PURPOSE
//  Streaming accumulate stage directly downstream of the 8x8 combinational multiplier.
//  - Consumes one 16-bit unsigned product per accepted beat.
//  - Sums a group of products, delimited by prod_last, into a wide accumulator (dot-product / MAC use).
//  - Presents the group sum and its beat count on a valid/ready output.
//  - Holds the result until the sink takes it.
// PARAMETERS
//  PROD_W   16   product width; matches the multiplier product output
//  ACC_W    24   accumulator width; must be >= PROD_W
//  MAX_LEN  256  max beats per group; CNT_W = $clog2(MAX_LEN+1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  prod_valid in   1       upstream product valid
//  prod_ready out  1       stage can accept a product
//  prod_data  in   PROD_W  unsigned product from the multiplier
//  prod_last  in   1       final beat of the current group
//  acc_valid  out  1       group result valid
//  acc_ready  in   1       sink accepts the result
//  acc_data   out  ACC_W   group sum
//  acc_count  out  CNT_W   number of beats in the group (1..MAX_LEN)
//  acc_ovf    out  1       overflow occurred in the group (sticky per group)
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - state=ACCUM; acc_data=0, acc_count=0, acc_ovf=0, acc_valid=0.
//    - prod_ready is 1 in the first cycle after reset.
//    - Reset mid-group discards the partial sum and count.
//  - FSM has 2 states:
//    - ACCUM: prod_ready=1, acc_valid=0.
//    - DONE:  prod_ready=0, acc_valid=1.
//  - Beat accept = prod_valid & prod_ready (ACCUM only):
//    - acc <= acc + zero-extended prod_data (ACC_W+1-bit sum internally).
//    - count <= count + 1.
//    - Carry out of bit ACC_W-1 sets acc_ovf.
//  - ACCUM -> DONE on an accepted beat with prod_last=1, OR when the accepted beat makes count == MAX_LEN.
//    - The second case forces group end; the next beat starts a new group.
//  - Latency: acc_valid rises the cycle after the last beat is accepted.
//    - acc_data includes that beat.
//  - DONE: acc_data, acc_count and acc_ovf are held stable while acc_valid=1 and acc_ready=0.
//  - DONE -> ACCUM on acc_valid & acc_ready:
//    - Next cycle: acc=0, count=0, ovf=0, prod_ready=1.
//    - Exactly one bubble cycle between groups; no product is accepted in the handshake cycle.
//  - prod_valid with prod_ready=0 is ignored; upstream must hold data (standard valid/ready).
//  - No combinational path from any input to any output; prod_ready and acc_valid are decoded from state only.
//  - prod_last on the beat that also hits MAX_LEN gives a single group end, not two.
// CONFIGURATION
//  - Macro: MUL_PRODUCT_ACCUMULATOR_SATURATE_EN
//  - Defined:
//    - On carry out, acc clamps to 2^ACC_W-1 and acc_ovf=1.
//    - Further beats in the group keep acc at max; count still increments.
//  - Undefined:
//    - acc wraps modulo 2^ACC_W.
//    - acc_ovf=1 marks that at least one wrap occurred in the group.
// TESTING
//  - Reset, then 4 beats 0x0001,0x0002,0x0003,0x0004 (last on 4th)
//    -> acc_valid next cycle, acc_data=10, acc_count=4, acc_ovf=0.
//  - Single beat 0xFE01 (255*255) with last=1 -> acc_data=0xFE01, acc_count=1.
//  - Hold acc_ready=0 for 5 cycles, pulse prod_valid
//    -> prod_ready=0, outputs stable, no beat absorbed.
//  - Handshake completes -> next cycle prod_ready=1, acc=0.
//  - 256 beats of 0xFFFF, last never set
//    -> group ends at count=256, acc_data=0xFFFF00, acc_ovf=0.
//  - ACC_W=16, beats 0xFFFF,0x0002, last on 2nd:
//    - Macro undefined -> acc_data=0x0001, acc_ovf=1.
//    - Macro defined   -> acc_data=0xFFFF, acc_ovf=1.
//  - rst asserted after 3 of 5 beats, then 2 beats 0x0005,0x0006 with last
//    -> acc_data=11, acc_count=2.

Source files
------------

// File: rtl/mul_product_accumulator.sv
// Streaming accumulator after the 8x8 multiplier: sums a prod_last-delimited group of products.
// Optional MUL_PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum on overflow instead of wrapping.
module mul_product_accumulator #(
    parameter  int PROD_W  = 16,
    parameter  int ACC_W   = 24,
    parameter  int MAX_LEN = 256,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf
);

    localparam logic [0:0]       ST_ACCUM = 1'b0;
    localparam logic [0:0]       ST_DONE  = 1'b1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_group_end;

    always_comb begin
        w_accept    = prod_valid & (r_state == ST_ACCUM);
        w_sum       = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
        w_carry     = w_sum[ACC_W];
        w_cnt_inc   = r_cnt + CNT_W'(1);
        // A beat that fills the group to MAX_LEN ends it even without prod_last.
        w_group_end = prod_last | (w_cnt_inc == MAX_CNT);
`ifdef MUL_PRODUCT_ACCUMULATOR_SATURATE_EN
        w_acc_next  = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        w_acc_next  = w_sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_inc;
                        r_ovf <= r_ovf | w_carry;
                        if (w_group_end) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    // Result is held until taken; the handshake cycle itself is the inter-group bubble.
                    if (acc_ready) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign prod_ready = (r_state == ST_ACCUM);
    assign acc_valid  = (r_state == ST_DONE);
    assign acc_data   = r_acc;
    assign acc_count  = r_cnt;
    assign acc_ovf    = r_ovf;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench for mul_product_accumulator: default instance (ACC_W=24, MAX_LEN=256)
// plus a narrow instance (ACC_W=16, MAX_LEN=4) for overflow and forced group end.
module tb_mul_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default instance
    logic        a_valid, a_ready, a_last, a_acc_valid, a_acc_ready, a_ovf;
    logic [15:0] a_data;
    logic [23:0] a_acc_data;
    logic [8:0]  a_count;

    // narrow instance
    logic        b_valid, b_ready, b_last, b_acc_valid, b_acc_ready, b_ovf;
    logic [15:0] b_data;
    logic [15:0] b_acc_data;
    logic [2:0]  b_count;

    mul_product_accumulator u_dut_a (
        .clk(clk), .rst(rst),
        .prod_valid(a_valid), .prod_ready(a_ready), .prod_data(a_data), .prod_last(a_last),
        .acc_valid(a_acc_valid), .acc_ready(a_acc_ready), .acc_data(a_acc_data),
        .acc_count(a_count), .acc_ovf(a_ovf)
    );

    mul_product_accumulator #(.PROD_W(16), .ACC_W(16), .MAX_LEN(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .prod_valid(b_valid), .prod_ready(b_ready), .prod_data(b_data), .prod_last(b_last),
        .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_data(b_acc_data),
        .acc_count(b_count), .acc_ovf(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [15:0] d, input logic l);
        a_valid = 1'b1; a_data = d; a_last = l;
        tick();
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic b_beat(input logic [15:0] d, input logic l);
        b_valid = 1'b1; b_data = d; b_last = l;
        tick();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic a_take();
        a_acc_ready = 1'b1;
        tick();
        a_acc_ready = 1'b0;
    endtask

    task automatic b_take();
        b_acc_ready = 1'b1;
        tick();
        b_acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%0b exp=0", a_acc_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_prod_ready got=%0b exp=1", a_ready); end
        checks++; if (a_acc_data !== 24'd0) begin errors++; $display("FAIL reset_acc_data got=%0h exp=0", a_acc_data); end
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL reset_acc_count got=%0d exp=0", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_acc_ovf got=%0b exp=0", a_ovf); end
        rst = 1'b0;
        $display("reset: valid=%0b ready=%0b data=%0h count=%0d", a_acc_valid, a_ready, a_acc_data, a_count);
    endtask

    task automatic test_basic_group();
        for (int i = 1; i <= 4; i++) begin
            checks++; if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat=%0d got=%0b exp=0", i, a_acc_valid); end
            a_beat(16'(i), i == 4);
        end
        checks++; if (a_acc_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", a_acc_valid); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL basic_prod_ready got=%0b exp=0", a_ready); end
        checks++; if (a_acc_data !== 24'd10) begin errors++; $display("FAIL basic_data got=%0d exp=10", a_acc_data); end
        checks++; if (a_count !== 9'd4) begin errors++; $display("FAIL basic_count got=%0d exp=4", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%0b exp=0", a_ovf); end
        $display("basic group: data=%0d count=%0d ovf=%0b", a_acc_data, a_count, a_ovf);
        a_take();
        checks++; if (a_ready !== 1'b1 || a_acc_valid !== 1'b0) begin errors++; $display("FAIL basic_release got ready=%0b valid=%0b exp ready=1 valid=0", a_ready, a_acc_valid); end
        checks++; if (a_acc_data !== 24'd0 || a_count !== 9'd0) begin errors++; $display("FAIL basic_clear got data=%0h count=%0d exp 0/0", a_acc_data, a_count); end
    endtask

    task automatic test_single_and_stall();
        a_beat(16'hFE01, 1'b1);
        checks++; if (a_acc_data !== 24'h00FE01) begin errors++; $display("FAIL single_data got=%0h exp=fe01", a_acc_data); end
        checks++; if (a_count !== 9'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", a_count); end
        $display("single beat: data=%0h count=%0d", a_acc_data, a_count);
        // upstream offers a beat while the result is stalled
        a_valid = 1'b1; a_data = 16'h0007; a_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (a_ready !== 1'b0 || a_acc_valid !== 1'b1) begin errors++; $display("FAIL stall_hs cyc=%0d got ready=%0b valid=%0b exp ready=0 valid=1", c, a_ready, a_acc_valid); end
            checks++; if (a_acc_data !== 24'h00FE01 || a_count !== 9'd1 || a_ovf !== 1'b0) begin errors++; $display("FAIL stall_hold cyc=%0d got data=%0h count=%0d ovf=%0b exp fe01/1/0", c, a_acc_data, a_count, a_ovf); end
        end
        a_take();
        checks++; if (a_count !== 9'd0 || a_acc_data !== 24'd0) begin errors++; $display("FAIL bubble_no_accept got data=%0h count=%0d exp 0/0", a_acc_data, a_count); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready got=%0b exp=1", a_ready); end
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        checks++; if (a_acc_valid !== 1'b1 || a_acc_data !== 24'd7 || a_count !== 9'd1) begin errors++; $display("FAIL after_bubble got valid=%0b data=%0h count=%0d exp 1/7/1", a_acc_valid, a_acc_data, a_count); end
        $display("stall/bubble: held beat absorbed after bubble, data=%0h", a_acc_data);
        a_take();
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                checks++; if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid got=%0b exp=0", a_acc_valid); end
            end
            a_beat(16'hFFFF, 1'b0);
        end
        checks++; if (a_acc_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%0b exp=1", a_acc_valid); end
        checks++; if (a_count !== 9'd256) begin errors++; $display("FAIL max_count got=%0d exp=256", a_count); end
        checks++; if (a_acc_data !== 24'hFFFF00) begin errors++; $display("FAIL max_data got=%0h exp=ffff00", a_acc_data); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got=%0b exp=0", a_ovf); end
        $display("max length: data=%0h count=%0d ovf=%0b", a_acc_data, a_count, a_ovf);
        a_take();
    endtask

    task automatic test_narrow_max_and_last();
        for (int i = 0; i < 4; i++) b_beat(16'd1, 1'b0);
        checks++; if (b_acc_valid !== 1'b1 || b_count !== 3'd4 || b_acc_data !== 16'd4) begin errors++; $display("FAIL narrow_max got valid=%0b count=%0d data=%0h exp 1/4/4", b_acc_valid, b_count, b_acc_data); end
        b_take();
        for (int i = 0; i < 4; i++) b_beat(16'd2, i == 3);
        checks++; if (b_acc_valid !== 1'b1 || b_count !== 3'd4 || b_acc_data !== 16'd8) begin errors++; $display("FAIL last_at_max got valid=%0b count=%0d data=%0h exp 1/4/8", b_acc_valid, b_count, b_acc_data); end
        b_take();
        tick();
        checks++; if (b_acc_valid !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL last_at_max_single got valid=%0b count=%0d exp 0/0", b_acc_valid, b_count); end
        $display("narrow: prod_last on MAX_LEN beat gave one group end");
    endtask

    task automatic test_overflow();
        logic [15:0] exp_data;
`ifdef MUL_PRODUCT_ACCUMULATOR_SATURATE_EN
        exp_data = 16'hFFFF;
`else
        exp_data = 16'h0001;
`endif
        b_beat(16'hFFFF, 1'b0);
        b_beat(16'h0002, 1'b1);
        checks++; if (b_acc_data !== exp_data) begin errors++; $display("FAIL ovf_data got=%0h exp=%0h", b_acc_data, exp_data); end
        checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", b_ovf); end
        checks++; if (b_count !== 3'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", b_count); end
        $display("overflow: data=%0h ovf=%0b", b_acc_data, b_ovf);
        b_take();
        checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", b_ovf); end
    endtask

    task automatic test_mid_group_reset();
        for (int i = 0; i < 3; i++) a_beat(16'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (a_count !== 9'd0 || a_acc_data !== 24'd0 || a_ready !== 1'b1) begin errors++; $display("FAIL midreset_clear got count=%0d data=%0h ready=%0b exp 0/0/1", a_count, a_acc_data, a_ready); end
        a_beat(16'd5, 1'b0);
        a_beat(16'd6, 1'b1);
        checks++; if (a_acc_valid !== 1'b1 || a_acc_data !== 24'd11 || a_count !== 9'd2) begin errors++; $display("FAIL midreset_group got valid=%0b data=%0d count=%0d exp 1/11/2", a_acc_valid, a_acc_data, a_count); end
        $display("mid-group reset: data=%0d count=%0d", a_acc_data, a_count);
        a_take();
    endtask

    initial begin
        a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_acc_ready = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_acc_ready = 1'b0;
        test_reset();
        test_basic_group();
        test_single_and_stall();
        test_max_len();
        test_narrow_max_and_last();
        test_overflow();
        test_mid_group_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
